// File: rtl/mat_csc_gen.sv
// Chaotic-random sparse matrix generator: streams CSC column pointers and
// (row, value, column) entries built from a random word stream.
module mat_csc_gen #(
    parameter int unsigned RAND_W       = 32,
    parameter int unsigned SUBCAR_NUM   = 16,
    parameter int unsigned OFDM_SYM_NUM = 16,
    parameter int unsigned MAT_COLS     = 256,
    parameter int unsigned NNZ_MAX      = 4,
    parameter int unsigned VAL_W        = 16,
    localparam int unsigned ROWS  = SUBCAR_NUM * OFDM_SYM_NUM,
    localparam int unsigned ROW_W = $clog2(ROWS),
    localparam int unsigned COL_W = $clog2(MAT_COLS),
    localparam int unsigned KW    = $clog2(NNZ_MAX),
    localparam int unsigned PTR_W = $clog2(MAT_COLS * NNZ_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [RAND_W-1:0] rand_data,
    input  logic              rand_vld,
    output logic              rand_rdy,
    output logic [PTR_W-1:0]  ptr_data,
    output logic              ptr_vld,
    input  logic              ptr_rdy,
    output logic [ROW_W-1:0]  ent_row,
    output logic [VAL_W-1:0]  ent_val,
    output logic [COL_W-1:0]  ent_col,
    output logic              ent_last_col,
    output logic              ent_vld,
    input  logic              ent_rdy
);

    localparam int unsigned CNT_W = KW + 1;
    localparam int unsigned KW_S  = (KW == 0) ? 1 : KW;

    typedef enum logic [2:0] {
        IDLE,
        COL_HDR,
        ENTRY,
        FINAL_PTR,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [PTR_W-1:0]   nnz_q, nnz_d;
    logic [CNT_W-1:0]   col_nnz_q, col_nnz_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [ROW_W-1:0]   rows_q [NNZ_MAX];
    logic [ROW_W-1:0]   rows_d [NNZ_MAX];
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PTR_W-1:0]   ptr_data_q, ptr_data_d;
    logic               ptr_vld_q, ptr_vld_d;
    logic [ROW_W-1:0]   ent_row_q, ent_row_d;
    logic [VAL_W-1:0]   ent_val_q, ent_val_d;
    logic [COL_W-1:0]   ent_col_q, ent_col_d;
    logic               ent_last_q, ent_last_d;
    logic               ent_vld_q, ent_vld_d;

    logic               take;
    logic [CNT_W-1:0]   hdr_nnz;
    logic [ROW_W-1:0]   new_row;
    logic [VAL_W-1:0]   new_val;
    logic [VAL_W-1:0]   fix_val;
    logic               dup;
    logic               is_last;
    logic               last_col;
    logic               unused_rand;

    // A word can only be taken when the stream it feeds has room
    assign rand_rdy = ((state_q == COL_HDR) && (!ptr_vld_q || ptr_rdy)) ||
                      ((state_q == ENTRY)   && (!ent_vld_q || ent_rdy));
    assign take     = rand_vld && rand_rdy;

    assign busy         = busy_q;
    assign done         = done_q;
    assign ptr_data     = ptr_data_q;
    assign ptr_vld      = ptr_vld_q;
    assign ent_row      = ent_row_q;
    assign ent_val      = ent_val_q;
    assign ent_col      = ent_col_q;
    assign ent_last_col = ent_last_q;
    assign ent_vld      = ent_vld_q;
    assign unused_rand  = ^rand_data;

    // Word field decode and duplicate-row search over rows already accepted
    always_comb begin
        hdr_nnz  = (KW == 0) ? CNT_W'(1)
                             : CNT_W'(rand_data[RAND_W-1 -: KW_S]) + CNT_W'(1);
        new_row  = rand_data[RAND_W-1 -: ROW_W];
        new_val  = rand_data[VAL_W-1:0];
        fix_val  = (new_val == '0) ? VAL_W'(1) : new_val;
        is_last  = ((acc_q + CNT_W'(1)) == col_nnz_q);
        last_col = (col_q == COL_W'(MAT_COLS - 1));
        dup      = 1'b0;
        for (int i = 0; i < int'(NNZ_MAX); i++) begin
            if ((CNT_W'(i) < acc_q) && (rows_q[i] == new_row)) begin
                dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        nnz_d      = nnz_q;
        col_nnz_d  = col_nnz_q;
        acc_d      = acc_q;
        rows_d     = rows_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ptr_data_d = ptr_data_q;
        ptr_vld_d  = ptr_vld_q && !ptr_rdy;
        ent_row_d  = ent_row_q;
        ent_val_d  = ent_val_q;
        ent_col_d  = ent_col_q;
        ent_last_d = ent_last_q;
        ent_vld_d  = ent_vld_q && !ent_rdy;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COL_HDR;
                    col_d   = '0;
                    nnz_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            COL_HDR: begin
                if (take) begin
                    col_nnz_d  = hdr_nnz;
                    acc_d      = '0;
                    for (int i = 0; i < int'(NNZ_MAX); i++) begin
                        rows_d[i] = '0;
                    end
                    ptr_data_d = nnz_q;
                    ptr_vld_d  = 1'b1;
                    state_d    = ENTRY;
                end
            end
            ENTRY: begin
                if (take && !dup) begin
                    for (int i = 0; i < int'(NNZ_MAX); i++) begin
                        if (CNT_W'(i) == acc_q) begin
                            rows_d[i] = new_row;
                        end
                    end
                    acc_d      = acc_q + CNT_W'(1);
                    nnz_d      = nnz_q + PTR_W'(1);
                    ent_row_d  = new_row;
                    ent_val_d  = fix_val;
                    ent_col_d  = col_q;
                    ent_last_d = is_last;
                    ent_vld_d  = 1'b1;
                    if (is_last) begin
                        if (last_col) begin
                            state_d = FINAL_PTR;
                        end else begin
                            col_d   = col_q + COL_W'(1);
                            state_d = COL_HDR;
                        end
                    end
                end
            end
            FINAL_PTR: begin
                if (!ptr_vld_q || ptr_rdy) begin
                    ptr_data_d = nnz_q;
                    ptr_vld_d  = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (!ptr_vld_q || ptr_rdy) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            nnz_q      <= '0;
            col_nnz_q  <= '0;
            acc_q      <= '0;
            for (int i = 0; i < int'(NNZ_MAX); i++) begin
                rows_q[i] <= '0;
            end
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ptr_data_q <= '0;
            ptr_vld_q  <= 1'b0;
            ent_row_q  <= '0;
            ent_val_q  <= '0;
            ent_col_q  <= '0;
            ent_last_q <= 1'b0;
            ent_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            nnz_q      <= nnz_d;
            col_nnz_q  <= col_nnz_d;
            acc_q      <= acc_d;
            rows_q     <= rows_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ptr_data_q <= ptr_data_d;
            ptr_vld_q  <= ptr_vld_d;
            ent_row_q  <= ent_row_d;
            ent_val_q  <= ent_val_d;
            ent_col_q  <= ent_col_d;
            ent_last_q <= ent_last_d;
            ent_vld_q  <= ent_vld_d;
        end
    end

endmodule

// File: tb/tb_mat_csc_gen.sv
// Scoreboard bench for mat_csc_gen: a column-by-column reference model predicts
// the pointer and entry streams for each random word sequence fed to the DUT.
module tb_mat_csc_gen;

    localparam int unsigned RAND_W   = 32;
    localparam int unsigned SUBCAR   = 4;
    localparam int unsigned OFDM     = 4;
    localparam int unsigned MAT_COLS = 4;
    localparam int unsigned NNZ_MAX  = 4;
    localparam int unsigned VAL_W    = 16;
    localparam int unsigned ROW_W    = 4;
    localparam int unsigned COL_W    = 2;
    localparam int unsigned PTR_W    = 5;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [RAND_W-1:0] rand_data;
    logic              rand_vld;
    logic              rand_rdy;
    logic [PTR_W-1:0]  ptr_data;
    logic              ptr_vld;
    logic              ptr_rdy;
    logic [ROW_W-1:0]  ent_row;
    logic [VAL_W-1:0]  ent_val;
    logic [COL_W-1:0]  ent_col;
    logic              ent_last_col;
    logic              ent_vld;
    logic              ent_rdy;

    mat_csc_gen #(
        .RAND_W(RAND_W), .SUBCAR_NUM(SUBCAR), .OFDM_SYM_NUM(OFDM),
        .MAT_COLS(MAT_COLS), .NNZ_MAX(NNZ_MAX), .VAL_W(VAL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rand_data(rand_data), .rand_vld(rand_vld), .rand_rdy(rand_rdy),
        .ptr_data(ptr_data), .ptr_vld(ptr_vld), .ptr_rdy(ptr_rdy),
        .ent_row(ent_row), .ent_val(ent_val), .ent_col(ent_col),
        .ent_last_col(ent_last_col), .ent_vld(ent_vld), .ent_rdy(ent_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int row;
        int val;
        int col;
        int last;
    } ent_t;

    logic [31:0] wq[$];
    int          ptr_exp[$];
    ent_t        ent_exp[$];
    int          ptr_got[$];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int ent_rx   = 0;
    bit drv_en     = 1'b0;
    bit force_vld  = 1'b1;
    bit vld_always = 1'b0;
    bit rdy_always = 1'b1;
    bit ent_hold   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one header then words until col_nnz distinct rows are seen
    task automatic build_matrix(input int kind);
        int          total;
        int          need;
        int          row;
        int          val;
        bit          hit;
        int          seen[$];
        logic [31:0] pre[$];
        logic [31:0] w;
        ent_t        e;
        total = 0;
        for (int c = 0; c < int'(MAT_COLS); c++) begin
            ptr_exp.push_back(total);
            if (kind == 2)                 w = 32'hC000_0000;
            else if (kind == 1 && c == 0)  w = 32'h4000_0000;
            else                           w = $urandom;
            wq.push_back(w);
            need = int'(w / 32'h4000_0000) + 1;
            seen.delete();
            pre.delete();
            if (kind == 1 && c == 0) begin
                pre.push_back(32'h3000_0005);
                pre.push_back(32'h3000_0009);
                pre.push_back(32'h7000_0000);
            end
            while (seen.size() < need) begin
                if (pre.size() > 0) begin
                    w = pre.pop_front();
                end else if (kind == 2) begin
                    forever begin
                        w = $urandom;
                        hit = 1'b0;
                        foreach (seen[j]) if (seen[j] == int'(w / 32'h1000_0000)) hit = 1'b1;
                        if (!hit) break;
                    end
                end else begin
                    w = $urandom;
                    if ($urandom_range(3) == 0) w[31:28] = 4'($urandom_range(3));
                    if ($urandom_range(5) == 0) w[15:0] = 16'h0000;
                end
                wq.push_back(w);
                row = int'(w / 32'h1000_0000);
                val = int'(w % 32'h0001_0000);
                if (val == 0) val = 1;
                hit = 1'b0;
                foreach (seen[j]) if (seen[j] == row) hit = 1'b1;
                if (!hit) begin
                    seen.push_back(row);
                    total++;
                    e.row  = row;
                    e.val  = val;
                    e.col  = c;
                    e.last = (seen.size() == need) ? 1 : 0;
                    ent_exp.push_back(e);
                end
            end
        end
        ptr_exp.push_back(total);
    endtask

    // Random-word source: holds the head word until it is consumed
    initial begin
        bit fire;
        forever begin
            @(negedge clk);
            fire = rand_vld && rand_rdy && rst_n;
            @(posedge clk);
            #1;
            if (fire && wq.size() > 0) void'(wq.pop_front());
            if (drv_en && wq.size() > 0) begin
                rand_data = wq[0];
                rand_vld  = vld_always || ($urandom_range(3) != 0);
            end else begin
                rand_data = $urandom;
                rand_vld  = force_vld;
            end
            ptr_rdy = rdy_always || ($urandom_range(2) != 0);
            ent_rdy = !ent_hold && (rdy_always || ($urandom_range(2) != 0));
        end
    end

    // Monitor: pops expectations on each handshake and checks stall stability
    initial begin
        bit               ptr_stall = 1'b0;
        bit               ent_stall = 1'b0;
        logic [PTR_W-1:0] ptr_prev  = '0;
        logic [ROW_W-1:0] row_prev  = '0;
        logic [VAL_W-1:0] val_prev  = '0;
        int               pe;
        ent_t             ee;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ptr_stall = 1'b0;
                ent_stall = 1'b0;
            end else begin
                if (ptr_stall) begin
                    check("ptr_hold_vld", ptr_vld, 1);
                    check("ptr_hold_data", ptr_data, ptr_prev);
                end
                if (ent_stall) begin
                    check("ent_hold_vld", ent_vld, 1);
                    check("ent_hold_row", ent_row, row_prev);
                    check("ent_hold_val", ent_val, val_prev);
                end
                if (ptr_vld && ptr_rdy) begin
                    ptr_got.push_back(int'(ptr_data));
                    if (ptr_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ptr_unexpected: got %0d expected no pointer", ptr_data);
                    end else begin
                        pe = ptr_exp.pop_front();
                        check("ptr_data", ptr_data, pe);
                    end
                end
                if (ent_vld && ent_rdy) begin
                    ent_rx++;
                    if (ent_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ent_unexpected: got row %0d val %0d expected no entry", ent_row, ent_val);
                    end else begin
                        ee = ent_exp.pop_front();
                        check("ent_row", ent_row, ee.row);
                        check("ent_val", ent_val, ee.val);
                        check("ent_col", ent_col, ee.col);
                        check("ent_last_col", ent_last_col, ee.last);
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("busy_low_at_done", busy, 0);
                end
                ptr_stall = ptr_vld && !ptr_rdy;
                ent_stall = ent_vld && !ent_rdy;
                ptr_prev  = ptr_data;
                row_prev  = ent_row;
                val_prev  = ent_val;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rand_rdy"}, rand_rdy, 0);
        check({tag, "_ptr_vld"}, ptr_vld, 0);
        check({tag, "_ent_vld"}, ent_vld, 0);
        check({tag, "_ptr_data"}, ptr_data, 0);
        check({tag, "_ent_row"}, ent_row, 0);
        check({tag, "_ent_val"}, ent_val, 0);
        check({tag, "_ent_col"}, ent_col, 0);
        check({tag, "_ent_last"}, ent_last_col, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wq.delete();
        ptr_exp.delete();
        ent_exp.delete();
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_finish(input int d0, input int e0, input bit extra_start,
                               input int exp_ents, output int cyc);
        bit ok;
        cyc = 1;
        ok  = 1'b0;
        while (cyc < 3000 && !ok) begin
            @(negedge clk);
            cyc++;
            if (extra_start && cyc == 10) start = 1'b1;
            if (extra_start && cyc == 11) start = 1'b0;
            if (done_cnt > d0) ok = 1'b1;
        end
        check("done_seen", ok, 1);
        for (int i = 0; i < 200 && (ptr_exp.size() > 0 || ent_exp.size() > 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("ptr_queue_empty", ptr_exp.size(), 0);
        check("ent_queue_empty", ent_exp.size(), 0);
        check("words_all_used", wq.size(), 0);
        check("done_pulse_count", done_cnt - d0, 1);
        check("busy_after_done", busy, 0);
        check("ptr_count", ptr_got.size(), MAT_COLS + 1);
        if (exp_ents >= 0) check("ent_count", ent_rx - e0, exp_ents);
        if (!ok) do_reset();
    endtask

    task automatic run_matrix(input int kind, input bit extra_start, output int cyc);
        int d0;
        int e0;
        ptr_got.delete();
        d0 = done_cnt;
        e0 = ent_rx;
        build_matrix(kind);
        pulse_start();
        @(negedge clk);
        check("busy_after_start", busy, 1);
        wait_finish(d0, e0, extra_start, (kind == 2) ? 16 : -1, cyc);
    endtask

    initial begin
        int cyc;
        int d0;
        int e0;
        bit ok;
        rst_n     = 1'b0;
        start     = 1'b0;
        rand_vld  = 1'b1;
        rand_data = 32'hFFFF_FFFF;
        ptr_rdy   = 1'b1;
        ent_rdy   = 1'b1;

        // Reset with a valid word offered
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rdy_before_start", rand_rdy, 0);
        end
        force_vld = 1'b0;
        drv_en    = 1'b1;

        // Directed first column with a stalled entry consumer
        ptr_got.delete();
        d0 = done_cnt;
        e0 = ent_rx;
        ent_hold = 1'b1;
        build_matrix(1);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ent_vld) ok = 1'b1;
        end
        check("first_entry_seen", ok, 1);
        repeat (3) begin
            @(negedge clk);
            check("stall_rand_rdy", rand_rdy, 0);
            check("stall_ent_row", ent_row, 3);
            check("stall_ent_val", ent_val, 5);
            check("stall_ent_last", ent_last_col, 0);
        end
        ent_hold = 1'b0;
        wait_finish(d0, e0, 1'b0, -1, cyc);
        check("directed_ptr1", (ptr_got.size() > 1) ? ptr_got[1] : -1, 2);

        // Random matrices with random back-pressure and source gaps
        rdy_always = 1'b0;
        repeat (4) run_matrix(0, 1'b0, cyc);

        // Full-rate, all columns at NNZ_MAX with distinct rows
        rdy_always = 1'b1;
        vld_always = 1'b1;
        run_matrix(2, 1'b0, cyc);
        for (int i = 0; i < 5; i++) begin
            check("full_ptr_seq", (ptr_got.size() > i) ? ptr_got[i] : -1, 4 * i);
        end
        check("full_rate_cycles_ok", (cyc <= 24) ? 1 : 0, 1);

        // Start while busy is ignored
        rdy_always = 1'b0;
        vld_always = 1'b0;
        run_matrix(0, 1'b1, cyc);

        // Reset during ENTRY abandons the matrix
        build_matrix(0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (ent_vld) ok = 1'b1;
        end
        check("pre_reset_entry_seen", ok, 1);
        do_reset();
        repeat (4) begin
            @(negedge clk);
            check("post_reset_ptr_vld", ptr_vld, 0);
            check("post_reset_ent_vld", ent_vld, 0);
            check("post_reset_rand_rdy", rand_rdy, 0);
            check("post_reset_busy", busy, 0);
        end
        run_matrix(0, 1'b0, cyc);
        check("restart_ptr0", (ptr_got.size() > 0) ? ptr_got[0] : -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
